// File: rtl/adc_sample_packer.sv
// Packs SAMPLE_W-bit ADC samples into LANES-wide words with run-time lane order,
// valid/ready on both sides, a one-word output register and a zero-padded flush.
module adc_sample_packer #(
  parameter int SAMPLE_W = 16,
  parameter int LANES    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLE_W-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         order,
  input  logic                         flush,
  output logic [SAMPLE_W*LANES-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_partial,
  output logic [$clog2(LANES):0]       out_count
);
  localparam int CNT_W  = $clog2(LANES);
  localparam int WORD_W = SAMPLE_W * LANES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  logic [WORD_W-1:0] acc, acc_n, filled;
  logic [CNT_W-1:0]  lane_idx, lane_n, lane_sel;
  logic [CNT_W:0]    held;
  logic              order_lat, order_n, flush_pend, pend_n;
  logic              accept, out_free, eff_order, complete, load, load_partial;

  assign out_free  = ~out_valid | out_ready;
  assign in_ready  = ~flush_pend & ((lane_idx != LAST) | out_free);
  assign accept    = in_valid & in_ready;
  assign complete  = accept & (lane_idx == LAST);
  // The first sample of a word uses the live order input; later ones use the latched copy.
  assign eff_order = (lane_idx == '0) ? order : order_lat;
  assign lane_sel  = eff_order ? (LAST - lane_idx) : lane_idx;
  assign held      = {1'b0, lane_idx} + {{CNT_W{1'b0}}, accept};

  always_comb begin
    filled = acc;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (accept && (lane_sel == CNT_W'(l))) begin
        filled[l*SAMPLE_W +: SAMPLE_W] = in_data;
      end
    end
  end

  always_comb begin
    acc_n        = filled;
    lane_n       = lane_idx + CNT_W'(accept);
    order_n      = (accept && (lane_idx == '0)) ? order : order_lat;
    pend_n       = flush_pend;
    load         = 1'b0;
    load_partial = 1'b0;
    if (complete) begin
      // A flush coinciding with the completing sample is absorbed by the full word.
      load   = 1'b1;
      acc_n  = '0;
      lane_n = '0;
      pend_n = 1'b0;
    end else if ((flush || flush_pend) && (held != '0)) begin
      if (out_free) begin
        load         = 1'b1;
        load_partial = 1'b1;
        acc_n        = '0;
        lane_n       = '0;
        pend_n       = 1'b0;
      end else begin
        pend_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      lane_idx    <= '0;
      order_lat   <= 1'b0;
      flush_pend  <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
      out_count   <= '0;
    end else begin
      acc        <= acc_n;
      lane_idx   <= lane_n;
      order_lat  <= order_n;
      flush_pend <= pend_n;
      if (load) begin
        out_data    <= filled;
        out_valid   <= 1'b1;
        out_partial <= load_partial;
        out_count   <= held;
      end else if (out_valid && out_ready) begin
        out_data    <= '0;
        out_valid   <= 1'b0;
        out_partial <= 1'b0;
        out_count   <= '0;
      end
    end
  end

endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
- Packs a stream of SAMPLE_W-bit ADC samples into LANES-wide words for the host-bound FIFO write path.
- Lane order is selectable at run time. order=1 with LANES=2 gives the fixed 16-bit half-swap used on the current 32-bit capture path.
- Valid/ready on both sides, with a one-word output buffer.
- A flush request emits a zero-padded partial word at end of capture.

Parameters:
- SAMPLE_W, 16, bits per ADC sample (>=1).
- LANES, 2, samples per output word (>=2). CNT_W = clog2(LANES).

Ports:
- clk  input  1  single system clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  SAMPLE_W  ADC sample
- in_valid  input  1  sample present
- in_ready  output  1  packer accepts sample this cycle
- order  input  1  0: first sample in lane 0 (bits [SAMPLE_W-1:0]); 1: first sample in lane LANES-1 (MSBs)
- flush  input  1  single-cycle request to emit the current partial word
- out_data  output  SAMPLE_W*LANES  packed word
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts word
- out_partial  output  1  qualifies out_data: word was flushed with fewer than LANES samples
- out_count  output  CNT_W+1  number of valid samples in out_data (1..LANES)

Behaviour:
- Reset (async assert, sync release):
  - out_data=0, out_valid=0, out_partial=0, out_count=0.
  - Accumulator=0, lane_idx=0, flush_pend=0.
  - in_ready is combinational and becomes 1 right after reset.
- Sample accept = in_valid & in_ready.
- On accept, the sample is written into accumulator lane L:
  - order_lat=0: L = lane_idx.
  - order_lat=1: L = LANES-1-lane_idx.
  - lane_idx then increments.
- order is latched into order_lat on the accept with lane_idx=0. A change of order mid-word takes effect from the next word.
- Word complete: on accept with lane_idx=LANES-1, the full word (including this sample) moves to the output register next cycle.
  - out_valid=1, out_partial=0, out_count=LANES.
  - Accumulator is cleared and lane_idx returns to 0.
- Latency: last sample accepted at cycle N, out_valid=1 at cycle N+1.
- Output handshake: the word holds stable while out_valid & ~out_ready. It clears on out_valid & out_ready unless a new word loads in the same cycle.
- in_ready = ~flush_pend & ((lane_idx != LANES-1) | ~out_valid | out_ready).
  - Completing a word while the output drains in the same cycle is allowed: the new word loads with no bubble.
- Flush:
  - flush=1 with lane_idx=0 and no accept that cycle: ignored.
  - Otherwise a partial word is produced. A sample accepted in the same cycle is included first.
  - If that accept completes the word: normal full word, flush consumed, no extra empty word.
  - A partial word has unfilled lanes zero, out_partial=1, out_count = samples held.
  - If the output register is busy (out_valid & ~out_ready): set flush_pend, which holds in_ready=0. Emit the word on the first cycle the output is free, then clear flush_pend.
  - flush while flush_pend=1: no additional effect.
- Reset mid-word discards the accumulator and any pending flush. No partial word is emitted.
- in_data is don't-care when in_valid=0. No samples are ever dropped; backpressure only.

Test Plan:
- SAMPLE_W=16, LANES=2, order=0, out_ready=1; send 0x1111, 0x2222 -> out_data=0x22221111, out_count=2, out_partial=0, one cycle after the second accept.
- Same with order=1 -> out_data=0x11112222. Toggle order after the first sample -> that word remains 0x11112222 and the next word uses the new order.
- LANES=4, order=0; send 0xA,0xB,0xC then pulse flush -> out_data=0x0000_000C_000B_000A, out_partial=1, out_count=3. flush with lane_idx=0 -> no output.
- Backpressure: LANES=2, out_ready=0 after the first word is output -> in_ready=1 for one more sample, then 0 with lane_idx=1. Raise out_ready -> first word accepted, second word loads in the same cycle with no sample lost. Continuous 1000-sample random stream with random out_ready -> scoreboard matches exactly.
- Flush while output full (out_valid=1, out_ready=0, one sample held) -> in_ready=0, partial word appears the cycle after out_ready rises. Flush coincident with the completing sample -> exactly one full word.
- Assert rst asynchronously mid-word (lane_idx=1, out_valid=1) -> all outputs 0 immediately. Next two samples form a clean full word with no residue.
